// File: rtl/hmr_nmr_ctrl.sv
// rtl/hmr_nmr_ctrl.sv - N-modular redundancy group controller
// Lockstep/independent mode, resynch sequencing, mismatch counters and watchdog.
module hmr_nmr_ctrl #(
    parameter int unsigned NumCores         = 3,
    parameter int unsigned CntWidth         = 8,
    parameter int unsigned TimeoutCycles    = 1024,
    parameter logic        RedFixed         = 1'b0,
    parameter logic        DefaultRedundant = RedFixed
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         delay_resynch_i,
    input  logic                         setback_en_i,
    input  logic                         reload_setback_en_i,
    input  logic                         force_resynch_i,
    input  logic                         fetch_en_i,
    input  logic                         cores_synch_i,
    input  logic                         single_mismatch_i,
    input  logic [NumCores-1:0]          error_i,
    input  logic                         failure_i,
    input  logic                         unload_done_i,
    input  logic                         reload_done_i,
    input  logic                         cnt_clear_i,
    output logic                         setback_o,
    output logic                         resynch_req_o,
    output logic                         grp_in_independent_o,
    output logic                         pending_resynch_o,
    output logic                         timeout_o,
    output logic [NumCores*CntWidth-1:0] mismatch_cnt_o,
    output logic [1:0]                   state_o
);

    localparam logic [1:0] ST_INDEP  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;
    localparam logic [1:0] ST_RELOAD = 2'd3;
    localparam logic [1:0] ST_RESET  = DefaultRedundant ? ST_RUN : ST_INDEP;
    localparam int unsigned WdW      = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    generate
        if (NumCores != 2 && NumCores != 3) begin : g_bad_cores
            $error("hmr_nmr_ctrl: NumCores must be 2 (DMR) or 3 (TMR)");
        end
        if (TimeoutCycles < 2) begin : g_bad_timeout
            $error("hmr_nmr_ctrl: TimeoutCycles must be at least 2");
        end
    endgenerate

    logic [1:0]                         r_state;
    logic [1:0]                         w_state_nxt;
    logic                               r_pending;
    logic                               w_pending_nxt;
    logic                               r_setback;
    logic                               w_setback_nxt;
    logic                               r_timeout;
    logic                               w_timeout_hit;
    logic [WdW-1:0]                     r_wdog;
    logic [NumCores-1:0][CntWidth-1:0]  r_cnt;

    logic w_red_req;
    logic w_mode_override;
    logic w_trigger;
    logic w_wdog_expired;
    logic w_in_seq;

    assign w_red_req       = RedFixed | enable_i;
    assign w_mode_override = !RedFixed && !fetch_en_i;
    assign w_trigger       = single_mismatch_i | force_resynch_i | r_pending;
    assign w_wdog_expired  = (r_wdog == WdW'(TimeoutCycles - 1));
    assign w_in_seq        = (r_state == ST_UNLOAD) || (r_state == ST_RELOAD);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_setback_nxt = 1'b0;
        w_timeout_hit = 1'b0;
        if (w_mode_override) begin
            w_state_nxt   = enable_i ? ST_RUN : ST_INDEP;
            w_pending_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_INDEP: begin
                    if (w_red_req && cores_synch_i) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // Dropping out of redundancy beats any resynch trigger.
                    if (!w_red_req) begin
                        w_state_nxt   = ST_INDEP;
                        w_pending_nxt = 1'b0;
                    end else if (w_trigger) begin
                        if (delay_resynch_i) begin
                            w_pending_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = ST_UNLOAD;
                            w_pending_nxt = 1'b0;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (unload_done_i) begin
                        w_state_nxt   = ST_RELOAD;
                        w_setback_nxt = setback_en_i;
                    end else if (w_wdog_expired) begin
                        w_state_nxt   = ST_RUN;
                        w_setback_nxt = 1'b1;
                        w_timeout_hit = 1'b1;
                    end
                end
                default: begin
                    if (reload_done_i) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_wdog_expired) begin
                        w_state_nxt   = ST_RUN;
                        w_setback_nxt = 1'b1;
                        w_timeout_hit = 1'b1;
                    end else begin
                        w_setback_nxt = (single_mismatch_i | failure_i)
                                        & setback_en_i & reload_setback_en_i;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_RESET;
            r_pending <= 1'b0;
            r_setback <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_setback <= w_setback_nxt;
        end
    end

    // Watchdog restarts on every state change so UNLOAD and RELOAD each get a full budget.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if ((w_state_nxt != r_state) || !w_in_seq) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WdW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end else if (cnt_clear_i) begin
            r_timeout <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < NumCores; k++) begin
                if (cnt_clear_i) begin
                    r_cnt[k] <= '0;
                end else if (error_i[k] && single_mismatch_i && (r_cnt[k] != {CntWidth{1'b1}})) begin
                    r_cnt[k] <= r_cnt[k] + CntWidth'(1);
                end
            end
        end
    end

    assign setback_o            = r_setback;
    assign resynch_req_o        = (r_state == ST_UNLOAD);
    assign grp_in_independent_o = (r_state == ST_INDEP);
    assign pending_resynch_o    = r_pending;
    assign timeout_o            = r_timeout;
    assign mismatch_cnt_o       = r_cnt;
    assign state_o              = r_state;

endmodule

// File: tb/tb_hmr_nmr_ctrl.sv
// tb/tb_hmr_nmr_ctrl.sv - self-checking bench for hmr_nmr_ctrl (TMR fixed and DMR switchable)
module tb_hmr_nmr_ctrl;

    localparam int S_INDEP  = 0;
    localparam int S_RUN    = 1;
    localparam int S_UNLOAD = 2;
    localparam int S_RELOAD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en, dly, se, rse, frc, fetch, synch, sm, fail, ud, rd, clr;
    logic [2:0] err;

    logic       a_sb, a_rr, a_ind, a_pend, a_to;
    logic [5:0] a_cnt;
    logic [1:0] a_st;
    logic       b_sb, b_rr, b_ind, b_pend, b_to;
    logic [7:0] b_cnt;
    logic [1:0] b_st;

    int n_err = 0;
    int n_chk = 0;

    // Instance 0: TMR, permanently redundant. Instance 1: DMR, software-switchable.
    int p_rf[2]   = '{1, 0};
    int p_def[2]  = '{1, 0};
    int p_nc[2]   = '{3, 2};
    int p_cw[2]   = '{2, 4};
    int p_tmo[2]  = '{8, 16};

    int m_st[2];
    int m_pend[2];
    int m_sb[2];
    int m_to[2];
    int m_entry[2];
    int m_cnt[2][3];
    int n_edge = 0;

    hmr_nmr_ctrl #(
        .NumCores(3), .CntWidth(2), .TimeoutCycles(8),
        .RedFixed(1'b1), .DefaultRedundant(1'b1)
    ) u_tmr (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .delay_resynch_i(dly),
        .setback_en_i(se), .reload_setback_en_i(rse), .force_resynch_i(frc),
        .fetch_en_i(fetch), .cores_synch_i(synch), .single_mismatch_i(sm),
        .error_i(err), .failure_i(fail), .unload_done_i(ud), .reload_done_i(rd),
        .cnt_clear_i(clr), .setback_o(a_sb), .resynch_req_o(a_rr),
        .grp_in_independent_o(a_ind), .pending_resynch_o(a_pend), .timeout_o(a_to),
        .mismatch_cnt_o(a_cnt), .state_o(a_st)
    );

    hmr_nmr_ctrl #(
        .NumCores(2), .CntWidth(4), .TimeoutCycles(16),
        .RedFixed(1'b0), .DefaultRedundant(1'b0)
    ) u_dmr (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .delay_resynch_i(dly),
        .setback_en_i(se), .reload_setback_en_i(rse), .force_resynch_i(frc),
        .fetch_en_i(fetch), .cores_synch_i(synch), .single_mismatch_i(sm),
        .error_i(err[1:0]), .failure_i(fail), .unload_done_i(ud), .reload_done_i(rd),
        .cnt_clear_i(clr), .setback_o(b_sb), .resynch_req_o(b_rr),
        .grp_in_independent_o(b_ind), .pending_resynch_o(b_pend), .timeout_o(b_to),
        .mismatch_cnt_o(b_cnt), .state_o(b_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sm;
        logic [2:0] err;
        logic       frc, dly, ud, rd, se, clr;
        logic [1:0] st;
        logic       sb, pend;
        logic [1:0] c0, c1;
        logic       to;
    } row_t;

    row_t tbl[28];

    function automatic row_t rw(logic i_sm, logic [2:0] i_err, logic i_frc, logic i_dly,
                                logic i_ud, logic i_rd, logic i_se, logic i_clr,
                                logic [1:0] e_st, logic e_sb, logic e_pend,
                                logic [1:0] e_c0, logic [1:0] e_c1, logic e_to);
        row_t r;
        r.sm = i_sm; r.err = i_err; r.frc = i_frc; r.dly = i_dly;
        r.ud = i_ud; r.rd = i_rd; r.se = i_se; r.clr = i_clr;
        r.st = e_st; r.sb = e_sb; r.pend = e_pend; r.c0 = e_c0; r.c1 = e_c1; r.to = e_to;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = p_def[i] ? S_RUN : S_INDEP;
            m_pend[i] = 0; m_sb[i] = 0; m_to[i] = 0; m_entry[i] = n_edge;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        end
    endtask

    // Reference behaviour for one clock edge, phrased as the group's rules.
    task automatic model_step();
        n_edge++;
        for (int i = 0; i < 2; i++) begin
            int st, nst, npend, sb, hit, want_red, in_seq, expired, done, cmax;
            st = m_st[i]; nst = st; npend = m_pend[i]; sb = 0; hit = 0;
            want_red = p_rf[i] || en;
            in_seq = (st == S_UNLOAD) || (st == S_RELOAD);
            expired = in_seq && ((n_edge - m_entry[i]) >= p_tmo[i]);
            if (!p_rf[i] && !fetch) begin
                nst = en ? S_RUN : S_INDEP;
                npend = 0;
            end else if (st == S_INDEP) begin
                if (want_red && synch) nst = S_RUN;
            end else if (st == S_RUN) begin
                if (!want_red) begin
                    nst = S_INDEP; npend = 0;
                end else if (sm || frc || m_pend[i]) begin
                    if (dly) npend = 1;
                    else begin nst = S_UNLOAD; npend = 0; end
                end
            end else begin
                done = (st == S_UNLOAD) ? ud : rd;
                if (done) begin
                    nst = (st == S_UNLOAD) ? S_RELOAD : S_RUN;
                    sb = (st == S_UNLOAD) ? se : 0;
                end else if (expired) begin
                    nst = S_RUN; sb = 1; hit = 1;
                end else if (st == S_RELOAD) begin
                    sb = (sm || fail) && se && rse;
                end
            end
            cmax = (1 << p_cw[i]) - 1;
            for (int k = 0; k < p_nc[i]; k++) begin
                if (clr) m_cnt[i][k] = 0;
                else if (err[k] && sm && m_cnt[i][k] < cmax) m_cnt[i][k] = m_cnt[i][k] + 1;
            end
            if (hit) m_to[i] = 1;
            else if (clr) m_to[i] = 0;
            if (nst != st) m_entry[i] = n_edge;
            m_st[i] = nst; m_pend[i] = npend; m_sb[i] = sb;
        end
    endtask

    task automatic cmp_inst(input int i, input string tag, input logic [1:0] st, input logic sb,
                            input logic rr, input logic ind, input logic pend, input logic to,
                            input logic [31:0] cnt);
        string g;
        logic [31:0] ecnt;
        g = (i == 0) ? "tmr" : "dmr";
        ecnt = 0;
        for (int k = 0; k < p_nc[i]; k++) ecnt = ecnt | (32'(m_cnt[i][k]) << (k * p_cw[i]));
        chk($sformatf("%s/%s/state", tag, g), 32'(st), 32'(m_st[i]));
        chk($sformatf("%s/%s/setback", tag, g), 32'(sb), 32'(m_sb[i]));
        chk($sformatf("%s/%s/resynch_req", tag, g), 32'(rr), 32'(m_st[i] == S_UNLOAD));
        chk($sformatf("%s/%s/indep", tag, g), 32'(ind), 32'(m_st[i] == S_INDEP));
        chk($sformatf("%s/%s/pending", tag, g), 32'(pend), 32'(m_pend[i]));
        chk($sformatf("%s/%s/timeout", tag, g), 32'(to), 32'(m_to[i]));
        chk($sformatf("%s/%s/counters", tag, g), cnt, ecnt);
    endtask

    task automatic compare_all(input string tag);
        cmp_inst(0, tag, a_st, a_sb, a_rr, a_ind, a_pend, a_to, 32'(a_cnt));
        cmp_inst(1, tag, b_st, b_sb, b_rr, b_ind, b_pend, b_to, 32'(b_cnt));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        en = 1; fetch = 1; synch = 1; dly = 0; se = 0; rse = 0; frc = 0;
        sm = 0; fail = 0; ud = 0; rd = 0; clr = 0; err = 3'b000;
    endtask

    initial begin
        idle_inputs();
        tbl[0]  = rw(1, 3'b010, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
        tbl[1]  = rw(0, 3'b000, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
        tbl[2]  = rw(0, 3'b000, 0, 0, 1, 0, 1, 0, 3, 1, 0, 0, 1, 0);
        tbl[3]  = rw(0, 3'b000, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0);
        tbl[4]  = rw(0, 3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[5]  = rw(0, 3'b000, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        tbl[6]  = rw(0, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        tbl[7]  = rw(0, 3'b000, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
        tbl[8]  = rw(0, 3'b000, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 1, 0);
        tbl[9]  = rw(0, 3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[10] = rw(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[11] = rw(1, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        tbl[12] = rw(1, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
        tbl[13] = rw(1, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0);
        tbl[14] = rw(1, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0);
        tbl[15] = rw(1, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0);
        tbl[16] = rw(1, 3'b001, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        for (int r = 17; r < 25; r++)
            tbl[r] = rw(0, 3'b000, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        tbl[25] = rw(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        tbl[26] = rw(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[27] = rw(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        #12;
        model_reset();
        compare_all("reset");
        chk("reset/tmr_state_run", 32'(a_st), 32'(S_RUN));
        chk("reset/dmr_state_indep", 32'(b_st), 32'(S_INDEP));
        rst = 1'b0;

        for (int r = 0; r < 28; r++) begin
            sm = tbl[r].sm; err = tbl[r].err; frc = tbl[r].frc; dly = tbl[r].dly;
            ud = tbl[r].ud; rd = tbl[r].rd; se = tbl[r].se; clr = tbl[r].clr;
            cyc($sformatf("row%0d", r));
            chk($sformatf("row%0d/state", r), 32'(a_st), 32'(tbl[r].st));
            chk($sformatf("row%0d/setback", r), 32'(a_sb), 32'(tbl[r].sb));
            chk($sformatf("row%0d/pending", r), 32'(a_pend), 32'(tbl[r].pend));
            chk($sformatf("row%0d/cnt0", r), 32'(a_cnt[1:0]), 32'(tbl[r].c0));
            chk($sformatf("row%0d/cnt1", r), 32'(a_cnt[3:2]), 32'(tbl[r].c1));
            chk($sformatf("row%0d/timeout", r), 32'(a_to), 32'(tbl[r].to));
        end

        idle_inputs();
        pulse_reset("dmr_start");
        cyc("dmr_en_synch");
        chk("dmr/indep_to_run", 32'(b_st), 32'(S_RUN));
        en = 0;
        cyc("dmr_disable");
        chk("dmr/run_to_indep", 32'(b_st), 32'(S_INDEP));
        chk("tmr/fixed_ignores_enable", 32'(a_st), 32'(S_RUN));
        en = 1; synch = 0;
        cyc("dmr_no_synch");
        chk("dmr/wait_synch", 32'(b_st), 32'(S_INDEP));
        synch = 1;
        cyc("dmr_synch");
        chk("dmr/synch_to_run", 32'(b_st), 32'(S_RUN));
        sm = 1; err = 3'b001;
        cyc("dmr_mismatch");
        chk("dmr/unload", 32'(b_st), 32'(S_UNLOAD));
        sm = 0; err = 3'b000; en = 0;
        cyc("dmr_unload_disable");
        chk("dmr/unload_holds", 32'(b_st), 32'(S_UNLOAD));
        en = 1; ud = 1; se = 1;
        cyc("dmr_unload_done");
        chk("dmr/reload", 32'(b_st), 32'(S_RELOAD));
        chk("dmr/entry_setback", 32'(b_sb), 32'd1);
        ud = 0; sm = 1; rse = 1;
        cyc("dmr_reload_err");
        chk("dmr/reload_setback", 32'(b_sb), 32'd1);
        pulse_reset("dmr_rst_reload");
        chk("dmr/rst_state", 32'(b_st), 32'(S_INDEP));
        chk("dmr/rst_setback", 32'(b_sb), 32'd0);
        idle_inputs();
        fetch = 0;
        cyc("dmr_fetch_off_en");
        chk("dmr/fetch_off_run", 32'(b_st), 32'(S_RUN));
        en = 0;
        cyc("dmr_fetch_off_dis");
        chk("dmr/fetch_off_indep", 32'(b_st), 32'(S_INDEP));
        idle_inputs();

        for (int c = 0; c < 3000; c++) begin
            en    = ($urandom_range(7) != 0);
            fetch = ($urandom_range(15) != 0);
            synch = 1'($urandom_range(1));
            dly   = ($urandom_range(3) == 0);
            se    = 1'($urandom_range(1));
            rse   = 1'($urandom_range(1));
            frc   = ($urandom_range(7) == 0);
            sm    = ($urandom_range(3) == 0);
            err   = 3'($urandom_range(7));
            fail  = ($urandom_range(7) == 0);
            ud    = ($urandom_range(9) == 0);
            rd    = ($urandom_range(9) == 0);
            clr   = ($urandom_range(31) == 0);
            if ($urandom_range(299) == 0) pulse_reset($sformatf("rnd_rst%0d", c));
            cyc($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hmr_nmr_ctrl.md
Name: hmr_nmr_ctrl

Overview:
- Parametrised N-modular redundancy control unit: successor to the fixed TMR controller. Supports DMR and TMR groups via `NumCores`.
- Holds the group's lockstep/independent mode and drives software-assisted resynchronisation (unload, setback, reload).
- Keeps per-core saturating mismatch counters internally.
- Buffers resynch requests while `delay_resynch_i` is set, and aborts stuck unload/reload sequences with a watchdog.
- Sits between the HMR configuration registers and one core group.

Parameters:
- NumCores, 3, cores in the redundant group (2 = DMR, 3 = TMR; other values illegal, elaboration assertion).
- CntWidth, 8, width of each per-core mismatch counter.
- TimeoutCycles, 1024, watchdog limit for UNLOAD and RELOAD states (>= 2).
- RedFixed, 1'b0, group permanently redundant; enable_i ignored.
- DefaultRedundant, RedFixed, reset mode is RUN when 1, else INDEP.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  redundant mode requested (level)
- delay_resynch_i  in  1  hold pending resynch until deasserted
- setback_en_i  in  1  allow setback pulse on entering RELOAD
- reload_setback_en_i  in  1  allow setback on error during RELOAD
- force_resynch_i  in  1  single-cycle software resynch request
- fetch_en_i  in  1  cores started
- cores_synch_i  in  1  cores report synchronised state
- single_mismatch_i  in  1  recoverable mismatch this cycle
- error_i  in  NumCores  per-core mismatch flags
- failure_i  in  1  unrecoverable mismatch
- unload_done_i  in  1  software finished state unload (pulse)
- reload_done_i  in  1  software finished state reload (pulse)
- cnt_clear_i  in  1  clear all mismatch counters
- setback_o  out  1  registered core setback pulse
- resynch_req_o  out  1  high in UNLOAD
- grp_in_independent_o  out  1  high in INDEP
- pending_resynch_o  out  1  resynch buffered, waiting for delay release
- timeout_o  out  1  sticky watchdog flag; cleared by cnt_clear_i
- mismatch_cnt_o  out  NumCores*CntWidth  counters, core 0 in LSBs
- state_o  out  2  current state encoding

Behaviour:
- States: INDEP=0, RUN=1, UNLOAD=2, RELOAD=3.
- Reset values: state = DefaultRedundant ? RUN : INDEP. All counters, pending, timeout, setback and watchdog = 0.
- All outputs are registered or decoded directly from registered state. A transition is visible the cycle after its cause.
- Resynch trigger (RUN only) = single_mismatch_i | force_resynch_i | pending.
  - delay_resynch_i=1: set pending, stay in RUN.
  - delay_resynch_i=0: go to UNLOAD and clear pending.
- Counters (any state):
  - error_i[k] & single_mismatch_i increments counter k by one.
  - Counters saturate at all-ones and do not wrap.
  - cnt_clear_i has priority over a same-cycle increment.
- UNLOAD:
  - unload_done_i moves to RELOAD.
  - setback_o = setback_en_i on the following cycle, for one cycle only.
- RELOAD:
  - reload_done_i moves to RUN.
  - Otherwise, (single_mismatch_i | failure_i) & setback_en_i & reload_setback_en_i gives a one-cycle setback_o.
- Watchdog:
  - Counts cycles in UNLOAD/RELOAD and resets on every state change.
  - Reaching TimeoutCycles-1 forces RUN, sets timeout_o, and issues a one-cycle setback_o.
  - A done pulse in the same cycle wins over the timeout.
- Mode switching (ignored when RedFixed):
  - fetch_en_i=0: state = enable_i ? RUN : INDEP, regardless of current state; pending cleared.
  - RUN & !enable_i: go to INDEP, clear pending. Takes priority over a resynch trigger.
  - INDEP & enable_i & cores_synch_i: go to RUN.
  - Never leave UNLOAD/RELOAD on enable_i changes.
- Reset mid-sequence: aborts immediately to the reset state; setback_o drops in the same cycle (async).

Test Plan:
- TMR, DefaultRedundant=1: single_mismatch_i with error_i=3'b010, delay=0 -> next cycle state=UNLOAD, resynch_req_o=1, counter1=1.
- unload_done_i with setback_en_i=1 -> state=RELOAD, setback_o high exactly 1 cycle. reload_done_i -> RUN.
- delay_resynch_i=1, force_resynch_i pulse -> pending_resynch_o=1, state stays RUN. Deassert delay -> UNLOAD next cycle, pending=0.
- CntWidth=2: five mismatches on core 0 -> counter0=3 (saturated). cnt_clear_i together with a mismatch -> counter0=0.
- TimeoutCycles=8: enter UNLOAD, no done pulse -> after 8 cycles state=RUN, timeout_o=1, setback_o 1-cycle pulse.
- DMR, RedFixed=0: fetch_en_i=1, enable_i 1->0 in RUN -> INDEP. enable_i=1 with cores_synch_i=1 -> RUN. Assert rst_i during RELOAD -> state=INDEP immediately.
